// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared types and constants for the shift frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 1;

endpackage
`default_nettype wire

// File: rtl/shift_reg_ple.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ple
// Purpose  : WIDTH-bit register with parallel load and shift-left serial in.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ple
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // Load has priority so a new frame can start on the edge a shift would occur.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], i_ser_in};
    end
  end

  assign o_q   = r_q;
  assign o_msb = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/shift_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_sequencer
// Purpose  : Round-robin shares one serial shift frame between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module shift_frame_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             grant_id,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             busy
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam int c_gap_w = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP > 0) ? GAP - 1 : 0);

  state_t             r_state, w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_prio, r_grant, r_done;
  logic [WIDTH-1:0]   r_rx;
  logic               w_winner, w_accept, w_last_bit, w_gap_end, w_msb;
  logic [WIDTH-1:0]   w_shreg;

  // r_prio names the requester that wins a tie: the one not granted last.
  always_comb begin
    w_winner = REQ0;
    if (req_valid == 2'b11) begin
      w_winner = r_prio;
    end else if (req_valid[1]) begin
      w_winner = REQ1;
    end
  end

  assign w_last_bit = (r_cnt == c_cnt_last);
  assign w_gap_end  = (r_gap_cnt == c_gap_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    ser_en    = 1'b0;
    ser_out   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = w_winner ? 2'b10 : 2'b01;
          w_accept  = 1'b1;
          w_next    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_en  = 1'b1;
        ser_out = w_msb;
        if (w_last_bit) begin
          w_next = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_prio    <= REQ0;
      r_grant   <= REQ0;
      r_done    <= 1'b0;
      r_rx      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt   <= '0;
        r_grant <= w_winner;
        r_prio  <= ~w_winner;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
        if (w_last_bit) begin
          r_rx      <= {w_shreg[WIDTH-2:0], ser_in};
          r_done    <= 1'b1;
          r_gap_cnt <= '0;
        end
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
      end
    end
  end

  shift_reg_ple #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept),
    .i_data   (w_winner ? req_data1 : req_data0),
    .i_shift  (r_state == S_SHIFT),
    .i_ser_in (ser_in),
    .o_q      (w_shreg),
    .o_msb    (w_msb)
  );

  assign grant_id = r_grant;
  assign rx_data  = r_rx;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
